// File: rtl/pc_seq_pkg.sv
// Shared types and default constants for the next-PC sequencer.
// The optional redirect counter is enabled by defining PC_REDIRECT_CNT_EN.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        S_RESET    = 2'd0,
        S_FETCH    = 2'd1,
        S_STALL    = 2'd2,
        S_REDIRECT = 2'd3
    } pc_state_e;

    localparam int          PC_WIDTH_DEFAULT    = 32;
    localparam logic [31:0] PC_RESET_DEFAULT    = 32'h0000_0000;
    localparam int          PC_INC_DEFAULT      = 1;
    localparam int          REDIRECT_CNT_WIDTH  = 16;

endpackage

// File: rtl/pc_seq_sat_counter.sv
// Generic up-counter that sticks at its all-ones value instead of wrapping.
module pc_seq_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;
    logic             w_at_max;

    assign w_at_max = &r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_en && !w_at_max) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: sequential fetch, stall hold and branch redirect with one bubble.
// Define PC_REDIRECT_CNT_EN to add the saturating redirect_cnt output.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int               WIDTH    = PC_WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(PC_RESET_DEFAULT),
    parameter int               INC      = PC_INC_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             imem_ready,
    input  logic             hazard_stall,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    output logic [WIDTH-1:0] pc,
    output logic             pc_valid,
    output logic             flush
`ifdef PC_REDIRECT_CNT_EN
    ,
    output logic [REDIRECT_CNT_WIDTH-1:0] redirect_cnt
`endif
);

    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    pc_state_e        r_state;
    logic [WIDTH-1:0] r_pc;
    logic             r_pc_valid;
    logic             r_flush;

    logic [WIDTH-1:0] w_pc_inc;
    logic             w_redirect;

    // Wraps naturally at 2^WIDTH.
    assign w_pc_inc   = r_pc + INC_W;
    // Any state but reset honours a redirect, and it outranks stall and accept.
    assign w_redirect = br_taken && (r_state != S_RESET);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_RESET;
            r_pc       <= RESET_PC;
            r_pc_valid <= 1'b0;
            r_flush    <= 1'b0;
        end else if (w_redirect) begin
            r_state    <= S_REDIRECT;
            r_pc       <= br_target;
            r_pc_valid <= 1'b0;
            r_flush    <= 1'b1;
        end else begin
            case (r_state)
                S_RESET: begin
                    r_state    <= S_FETCH;
                    r_pc_valid <= 1'b1;
                    r_flush    <= 1'b0;
                end
                S_FETCH: begin
                    if (hazard_stall) begin
                        r_state    <= S_STALL;
                        r_pc_valid <= 1'b0;
                    end else if (imem_ready) begin
                        r_pc <= w_pc_inc;
                    end
                    r_flush <= 1'b0;
                end
                S_STALL: begin
                    if (!hazard_stall) begin
                        r_state    <= S_FETCH;
                        r_pc_valid <= 1'b1;
                    end
                    r_flush <= 1'b0;
                end
                S_REDIRECT: begin
                    r_state    <= S_FETCH;
                    r_pc_valid <= 1'b1;
                    r_flush    <= 1'b0;
                end
                default: begin
                    r_state    <= S_RESET;
                    r_pc_valid <= 1'b0;
                    r_flush    <= 1'b0;
                end
            endcase
        end
    end

    assign pc       = r_pc;
    assign pc_valid = r_pc_valid;
    assign flush    = r_flush;

`ifdef PC_REDIRECT_CNT_EN
    pc_seq_sat_counter #(
        .WIDTH (REDIRECT_CNT_WIDTH)
    ) u_redirect_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_redirect),
        .o_count (redirect_cnt)
    );
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; also exercises redirect_cnt when PC_REDIRECT_CNT_EN is defined.
module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        imem_ready;
    logic        hazard_stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] pc;
    logic        pc_valid;
    logic        flush;
`ifdef PC_REDIRECT_CNT_EN
    logic [15:0] redirect_cnt;
`endif

    int errors = 0;
    int checks = 0;

    pc_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_ready   (imem_ready),
        .hazard_stall (hazard_stall),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .pc           (pc),
        .pc_valid     (pc_valid),
        .flush        (flush)
`ifdef PC_REDIRECT_CNT_EN
        ,
        .redirect_cnt (redirect_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic ready, input logic stall,
                                 input logic br, input logic [31:0] target);
        imem_ready   = ready;
        hazard_stall = stall;
        br_taken     = br;
        br_target    = target;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkState(input string tag, input logic [31:0] expPc,
                              input logic expValid, input logic expFlush);
        checkOutput({tag, ".pc"}, pc, expPc);
        checkOutput({tag, ".pc_valid"}, {31'd0, pc_valid}, {31'd0, expValid});
        checkOutput({tag, ".flush"}, {31'd0, flush}, {31'd0, expFlush});
    endtask

    task automatic checkCount(input string tag, input logic [15:0] expCnt);
`ifdef PC_REDIRECT_CNT_EN
        checkOutput({tag, ".redirect_cnt"}, {16'd0, redirect_cnt}, {16'd0, expCnt});
`else
        if (expCnt == 16'hFFFF) $display("[TB] counter absent for %s", tag);
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        #12;
        checkState("reset", 32'h0, 1'b0, 1'b0);
        checkCount("reset", 16'd0);
        rst_n = 1'b1;
        #1;
        checkState("cycle0", 32'h0, 1'b0, 1'b0);

        // Sequential fetch after reset release.
        for (int i = 0; i <= 5; i++) begin
            stepClock();
            checkState($sformatf("seq%0d", i), 32'(i), 1'b1, 1'b0);
        end

        // Memory wait holds pc with the request still valid.
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            stepClock();
            checkState($sformatf("wait%0d", i), 32'h5, 1'b1, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        stepClock();
        checkState("wait_release", 32'h6, 1'b1, 1'b0);
        stepClock();
        checkState("pc7", 32'h7, 1'b1, 1'b0);

        // Taken branch at pc=7 with a simultaneous accept.
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h40);
        stepClock();
        checkState("redir40", 32'h40, 1'b0, 1'b1);
        checkCount("redir40", 16'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        stepClock();
        checkState("fetch40", 32'h40, 1'b1, 1'b0);
        stepClock();
        checkState("fetch41", 32'h41, 1'b1, 1'b0);

        // Reach pc=9 through a redirect, then stall and branch inside the stall.
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h9);
        stepClock();
        checkState("redir9", 32'h9, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        stepClock();
        checkState("fetch9", 32'h9, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        stepClock();
        checkState("stall1", 32'h9, 1'b0, 1'b0);
        stepClock();
        checkState("stall2", 32'h9, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h80);
        stepClock();
        checkState("redir80", 32'h80, 1'b0, 1'b1);
        checkCount("redir80", 16'd3);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        stepClock();
        checkState("fetch80", 32'h80, 1'b1, 1'b0);

        // Back-to-back redirects reload the target and keep flushing.
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h100);
        stepClock();
        checkState("redir100", 32'h100, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h200);
        stepClock();
        checkState("redir200", 32'h200, 1'b0, 1'b1);
        checkCount("redir200", 16'd5);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        stepClock();
        checkState("fetch200", 32'h200, 1'b1, 1'b0);

        // Stall released without a branch resumes at the held pc.
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        stepClock();
        checkState("stall200", 32'h200, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        stepClock();
        checkState("resume200", 32'h200, 1'b1, 1'b0);
        stepClock();
        checkState("fetch201", 32'h201, 1'b1, 1'b0);

        // Wrap-around of the increment.
        applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
        stepClock();
        checkState("redirMax", 32'hFFFF_FFFF, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        stepClock();
        checkState("fetchMax", 32'hFFFF_FFFF, 1'b1, 1'b0);
        stepClock();
        checkState("wrap", 32'h0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a redirect bubble.
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h1234);
        stepClock();
        checkState("redir1234", 32'h1234, 1'b0, 1'b1);
        checkCount("redir1234", 16'd7);
        rst_n = 1'b0;
        #1;
        checkState("asyncReset", 32'h0, 1'b0, 1'b0);
        checkCount("asyncReset", 16'd0);

        // Branch and stall are ignored while leaving reset.
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h55);
        @(negedge clk);
        rst_n = 1'b1;
        stepClock();
        checkState("resetExit", 32'h0, 1'b1, 1'b0);
        checkCount("resetExit", 16'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        stepClock();
        checkState("postReset", 32'h1, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
